// File: rtl/psum_glb_loader.sv
// psum_glb_loader
//   Streams X_dim partial-sum words out of the global buffer (GLB), packs
//   them into one wide vector and writes that vector into the PE psum
//   scratchpads with a single strobe. Each start pulse performs one load.
//   Successive loads walk through Y_dim consecutive X_dim-word blocks and
//   then wrap back to the first block.
//
// Ports
//   clk               single clock, rising edge
//   reset             asynchronous, active-low reset
//   load_psum_ctrl    start pulse from the PE cluster controller
//   read_en_glb_psum  GLB psum read strobe
//   r_addr_glb_psum   GLB psum read address
//   r_data_glb_psum   GLB read data, valid one cycle after the strobe
//   w_data_spad_psum  packed psum vector to the spads (slot 0 = LSBs)
//   load_en_spad_psum one-cycle write strobe for w_data_spad_psum
//   busy              high whenever the loader is not idle
//   pass_done         pulses with the load of the last block in a pass
module psum_glb_loader #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int Y_dim             = 3,
  parameter int PSUM_READ_ADDR    = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_psum_ctrl,
  output logic                              read_en_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0]      r_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]          r_data_glb_psum,
  output logic [DATA_BITWIDTH*X_dim-1:0]    w_data_spad_psum,
  output logic                              load_en_spad_psum,
  output logic                              busy,
  output logic                              pass_done
);

  localparam int CNT_W  = $clog2(X_dim + 1);
  localparam int ITER_W = (Y_dim > 1) ? $clog2(Y_dim) : 1;

  localparam logic [CNT_W-1:0]  LAST_RD   = CNT_W'(X_dim - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(Y_dim - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    LOAD
  } state_t;

  state_t                       state;
  logic [ITER_W-1:0]            iter;
  logic [CNT_W-1:0]             rd_count;
  logic [CNT_W-1:0]             wr_count;
  logic                         capture_valid;
  logic [ADDR_BITWIDTH_GLB-1:0] iter_base;

  // Start address of the current block; truncation to the address width
  // gives the required modulo-2^ADDR_BITWIDTH_GLB wrap.
  always_comb begin
    iter_base = ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR) + ADDR_BITWIDTH_GLB'(iter * X_dim);
  end

  // All outputs are registered: each branch sets the values the outputs
  // must carry in the state being entered. Capture runs alongside the FSM
  // because the last word returns while the FSM is already in DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      iter              <= '0;
      rd_count          <= '0;
      wr_count          <= '0;
      capture_valid     <= 1'b0;
      read_en_glb_psum  <= 1'b0;
      r_addr_glb_psum   <= ADDR_BITWIDTH_GLB'(PSUM_READ_ADDR);
      w_data_spad_psum  <= '0;
      load_en_spad_psum <= 1'b0;
      busy              <= 1'b0;
      pass_done         <= 1'b0;
    end else begin
      // GLB data lags the strobe by one cycle, so the strobe delayed by one
      // cycle marks which r_data_glb_psum samples are real words.
      capture_valid <= read_en_glb_psum;
      if (capture_valid) begin
        for (int k = 0; k < X_dim; k++) begin
          if (wr_count == CNT_W'(k)) begin
            w_data_spad_psum[k*DATA_BITWIDTH +: DATA_BITWIDTH] <= r_data_glb_psum;
          end
        end
        wr_count <= wr_count + 1'b1;
      end

      case (state)
        IDLE: begin
          read_en_glb_psum  <= 1'b0;
          load_en_spad_psum <= 1'b0;
          pass_done         <= 1'b0;
          if (load_psum_ctrl) begin
            state            <= READ;
            busy             <= 1'b1;
            read_en_glb_psum <= 1'b1;
            r_addr_glb_psum  <= iter_base;
            rd_count         <= '0;
            wr_count         <= '0;
          end
        end
        READ: begin
          if (rd_count == LAST_RD) begin
            state            <= DRAIN;
            read_en_glb_psum <= 1'b0;
          end else begin
            rd_count        <= rd_count + 1'b1;
            r_addr_glb_psum <= r_addr_glb_psum + 1'b1;
          end
        end
        DRAIN: begin
          // iter still names the block being loaded, so it decides pass_done.
          state             <= LOAD;
          load_en_spad_psum <= 1'b1;
          pass_done         <= (iter == LAST_ITER);
        end
        LOAD: begin
          state             <= IDLE;
          load_en_spad_psum <= 1'b0;
          pass_done         <= 1'b0;
          busy              <= 1'b0;
          iter              <= (iter == LAST_ITER) ? '0 : iter + 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_glb_loader.sv
// tb_psum_glb_loader
//   Directed bench for psum_glb_loader. Two instances share clock and reset:
//   one with default parameters and one with PSUM_READ_ADDR=1020 to exercise
//   address wrap. useW selects which instance the stimulus drives and which
//   outputs are observed. The GLB model returns 100+address one cycle after
//   each read strobe.
module tb_psum_glb_loader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int XD = 5;
  localparam int YD = 3;

  logic clk;
  logic reset;
  logic startReq;
  logic useW;
  logic start0;
  logic startW;

  logic              rdEn0, ldEn0, busy0, pd0;
  logic [AW-1:0]     addr0;
  logic [DW-1:0]     rdata0;
  logic [DW*XD-1:0]  wdata0;

  logic              rdEnW, ldEnW, busyW, pdW;
  logic [AW-1:0]     addrW;
  logic [DW-1:0]     rdataW;
  logic [DW*XD-1:0]  wdataW;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  assign start0 = startReq & ~useW;
  assign startW = startReq & useW;

  wire              obsRdEn = useW ? rdEnW : rdEn0;
  wire              obsLdEn = useW ? ldEnW : ldEn0;
  wire              obsBusy = useW ? busyW : busy0;
  wire              obsPd   = useW ? pdW   : pd0;
  wire [AW-1:0]     obsAddr = useW ? addrW : addr0;
  wire [DW*XD-1:0]  obsData = useW ? wdataW : wdata0;

  psum_glb_loader #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD), .Y_dim(YD),
    .PSUM_READ_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset), .load_psum_ctrl(start0),
    .read_en_glb_psum(rdEn0), .r_addr_glb_psum(addr0), .r_data_glb_psum(rdata0),
    .w_data_spad_psum(wdata0), .load_en_spad_psum(ldEn0), .busy(busy0),
    .pass_done(pd0)
  );

  psum_glb_loader #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .X_dim(XD), .Y_dim(YD),
    .PSUM_READ_ADDR(1020)
  ) dutWrap (
    .clk(clk), .reset(reset), .load_psum_ctrl(startW),
    .read_en_glb_psum(rdEnW), .r_addr_glb_psum(addrW), .r_data_glb_psum(rdataW),
    .w_data_spad_psum(wdataW), .load_en_spad_psum(ldEnW), .busy(busyW),
    .pass_done(pdW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdEn0) rdata0 <= 16'd100 + 16'(addr0);
    if (rdEnW) rdataW <= 16'd100 + 16'(addrW);
  end

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s);
    startReq = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("rst_rd_en", 80'(obsRdEn), 80'(1'b0));
    checkOutput("rst_ld_en", 80'(obsLdEn), 80'(1'b0));
    checkOutput("rst_busy", 80'(obsBusy), 80'(1'b0));
    checkOutput("rst_pass_done", 80'(obsPd), 80'(1'b0));
    checkOutput("rst_addr", 80'(obsAddr), useW ? 80'(1020) : 80'(0));
    checkOutput("rst_data", 80'(obsData), 80'(0));
    step();
    step();
    reset = 1'b1;
  endtask

  // One full load: start pulse, X_dim reads, drain, load, return to idle.
  task automatic runLoad(input int base, input logic expPass);
    logic [79:0]   expVec;
    logic [AW-1:0] ea;
    expVec = '0;
    applyStimulus(1'b1);
    step();
    applyStimulus(1'b0);
    checkOutput("busy_start", 80'(obsBusy), 80'(1'b1));
    for (int k = 0; k < XD; k++) begin
      ea = AW'(base + k);
      expVec[k*DW +: DW] = 16'd100 + 16'(ea);
      checkOutput($sformatf("rd_en_%0d", k), 80'(obsRdEn), 80'(1'b1));
      checkOutput($sformatf("rd_addr_%0d", k), 80'(obsAddr), 80'(ea));
      checkOutput($sformatf("ld_in_read_%0d", k), 80'(obsLdEn), 80'(1'b0));
      step();
    end
    checkOutput("drain_rd_en", 80'(obsRdEn), 80'(1'b0));
    checkOutput("drain_ld_en", 80'(obsLdEn), 80'(1'b0));
    step();
    checkOutput("load_en", 80'(obsLdEn), 80'(1'b1));
    checkOutput("load_data", obsData, expVec);
    checkOutput("load_pass_done", 80'(obsPd), 80'(expPass));
    checkOutput("load_rd_en", 80'(obsRdEn), 80'(1'b0));
    checkOutput("load_busy", 80'(obsBusy), 80'(1'b1));
    step();
    checkOutput("ld_en_drop", 80'(obsLdEn), 80'(1'b0));
    checkOutput("pass_drop", 80'(obsPd), 80'(1'b0));
    checkOutput("busy_fall", 80'(obsBusy), 80'(1'b0));
    checkOutput("data_hold", obsData, expVec);
  endtask

  initial begin
    int loadAt[$];
    int overlap;
    int readCycles;
    int rdIdx;
    int loads;

    reset = 1'b1;
    startReq = 1'b0;
    useW = 1'b0;
    #2;

    $display("[TB] single load after reset");
    doReset();
    runLoad(0, 1'b0);

    $display("[TB] three loads and wrap of the block index");
    doReset();
    runLoad(0, 1'b0);
    runLoad(5, 1'b0);
    runLoad(10, 1'b1);
    runLoad(0, 1'b0);

    $display("[TB] start held high");
    doReset();
    overlap = 0;
    readCycles = 0;
    applyStimulus(1'b1);
    for (int c = 1; c <= 38; c++) begin
      step();
      if (obsLdEn) loadAt.push_back(c);
      if (obsRdEn) readCycles++;
      if (obsRdEn && obsLdEn) overlap++;
      if (c == 30) applyStimulus(1'b0);
    end
    checkOutput("held_load_count", 80'(loadAt.size()), 80'(4));
    if (loadAt.size() > 0) checkOutput("held_first_load", 80'(loadAt[0]), 80'(7));
    for (int i = 1; i < loadAt.size(); i++) begin
      checkOutput($sformatf("held_gap_%0d", i), 80'(loadAt[i] - loadAt[i-1]), 80'(8));
    end
    checkOutput("held_overlap", 80'(overlap), 80'(0));
    checkOutput("held_read_cycles", 80'(readCycles), 80'(20));
    checkOutput("held_idle_end", 80'(obsBusy), 80'(1'b0));

    $display("[TB] start pulses while busy");
    doReset();
    rdIdx = 0;
    loads = 0;
    applyStimulus(1'b1);
    step();
    applyStimulus(1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (obsRdEn) begin
        checkOutput($sformatf("busy_addr_%0d", rdIdx), 80'(obsAddr), 80'(rdIdx));
        rdIdx++;
      end
      if (obsLdEn) loads++;
      applyStimulus((c == 2) || (c == 6));
      step();
    end
    applyStimulus(1'b0);
    checkOutput("busy_read_count", 80'(rdIdx), 80'(5));
    checkOutput("busy_load_count", 80'(loads), 80'(1));
    checkOutput("busy_idle_end", 80'(obsBusy), 80'(1'b0));

    $display("[TB] reset during the third read cycle");
    doReset();
    runLoad(0, 1'b0);
    applyStimulus(1'b1);
    step();
    applyStimulus(1'b0);
    step();
    step();
    checkOutput("pre_reset_rd_en", 80'(obsRdEn), 80'(1'b1));
    checkOutput("pre_reset_addr", 80'(obsAddr), 80'(7));
    reset = 1'b0;
    #1;
    checkOutput("abort_rd_en", 80'(obsRdEn), 80'(1'b0));
    checkOutput("abort_busy", 80'(obsBusy), 80'(1'b0));
    checkOutput("abort_addr", 80'(obsAddr), 80'(0));
    checkOutput("abort_data", obsData, 80'(0));
    loads = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (obsLdEn) loads++;
    end
    checkOutput("abort_no_load", 80'(loads), 80'(0));
    reset = 1'b1;
    runLoad(0, 1'b0);

    $display("[TB] address wrap with base 1020");
    useW = 1'b1;
    doReset();
    runLoad(1020, 1'b0);
    runLoad(1025, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/psum_glb_loader.md
PSUM_GLB_LOADER -- requirements
Module: psum_glb_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_BITWIDTH, 16, width of one psum word
- ADDR_BITWIDTH_GLB, 10, GLB psum address width
- X_dim, 5, psum words packed per spad load (PE columns)
- Y_dim, 3, loads per pass (iterations before wrap)
- PSUM_READ_ADDR, 0, GLB base address of the psum region
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all logic on its rising edge
- reset, in, 1, asynchronous, active-low reset
- load_psum_ctrl, in, 1, start pulse from the PE cluster controller
- read_en_glb_psum, out, 1, GLB psum read strobe
- r_addr_glb_psum, out, ADDR_BITWIDTH_GLB, GLB psum read address
- r_data_glb_psum, in, DATA_BITWIDTH, GLB read data; valid 1 cycle after the strobe
- w_data_spad_psum, out, DATA_BITWIDTH*X_dim, packed psum vector to the PE psum spads
- load_en_spad_psum, out, 1, 1-cycle write strobe for w_data_spad_psum
- busy, out, 1, high in any state other than IDLE
- pass_done, out, 1, 1-cycle pulse when load Y_dim-1 completes

Function
REQ-003 The FSM SHALL have four states: IDLE, READ, DRAIN, LOAD.
REQ-004 IDLE: if load_psum_ctrl=1, go to READ with rd_count=0; otherwise stay in IDLE with all strobes low.
REQ-005 READ: drive read_en_glb_psum=1 and r_addr_glb_psum = PSUM_READ_ADDR + iter*X_dim + rd_count (modulo 2^ADDR_BITWIDTH_GLB); increment rd_count each cycle.
REQ-006 READ SHALL last exactly X_dim consecutive cycles, then move to DRAIN.
REQ-007 DRAIN SHALL last 1 cycle with read_en_glb_psum=0, then move to LOAD.
REQ-008 A capture valid flag SHALL be read_en_glb_psum delayed by 1 cycle. When it is set, r_data_glb_psum SHALL be written into slot wr_count, bits [(wr_count+1)*DATA_BITWIDTH-1 -: DATA_BITWIDTH], and wr_count SHALL then increment.
REQ-009 Word k read from the GLB SHALL land in slot k; slot 0 is the LSBs.
REQ-010 LOAD: drive load_en_spad_psum=1 for exactly 1 cycle while w_data_spad_psum holds all X_dim captured words; then return to IDLE.
REQ-011 Latency from load_psum_ctrl sampled high to load_en_spad_psum high SHALL be X_dim+2 cycles.
REQ-012 w_data_spad_psum SHALL hold its value between loads. It SHALL change only during capture cycles.
REQ-013 In LOAD, iter SHALL increment. If iter == Y_dim-1, iter SHALL wrap to 0 and pass_done SHALL pulse in the same cycle as load_en_spad_psum.
REQ-014 load_psum_ctrl SHALL be ignored while busy=1; no queuing.
REQ-015 If load_psum_ctrl is held high, a new load SHALL start in the cycle after LOAD. Back-to-back loads are therefore X_dim+3 cycles apart.
REQ-016 rd_count and wr_count SHALL be wide enough for X_dim and SHALL reset to 0 on entry to READ.
REQ-017 Data arriving while the capture valid flag is 0 SHALL be ignored.

Reset
REQ-018 Assertion of reset (low) SHALL take effect immediately, independent of clk.
REQ-019 On reset, the following SHALL clear: state=IDLE; iter, rd_count, wr_count, the capture valid flag, read_en_glb_psum, load_en_spad_psum, busy and pass_done all 0; r_addr_glb_psum=PSUM_READ_ADDR; w_data_spad_psum all 0.
REQ-020 Reset mid-operation SHALL abort the load with no load_en_spad_psum pulse. The first start after deassertion SHALL use iter=0.
REQ-021 Deassertion SHALL be synchronous to clk; the first start is accepted on the first rising edge after release.

Verification
REQ-022 The bench SHALL cover these directed scenarios (defaults; GLB model returns 100+address, 1-cycle latency):
- Single start after reset -> reads at addresses 0..4 on 5 consecutive cycles; load_en_spad_psum at cycle 7; packed vector slots 0..4 = 100..104; busy falls after LOAD.
- Three starts -> the loads read bases 0, 5, 10; pass_done pulses only with the third load; a fourth start reads base 0 again.
- load_psum_ctrl held high for 30 cycles -> loads exactly 8 cycles apart; no overlap of read_en_glb_psum with LOAD.
- Start pulsed during READ and during DRAIN -> ignored; exactly one load_en_spad_psum; addresses unchanged.
- Reset asserted during the 3rd READ cycle -> all outputs clear immediately; no load strobe; the next start reads from address 0.
- PSUM_READ_ADDR=1020, ADDR_BITWIDTH_GLB=10, second load -> addresses 1, 2, 3, 4, 5 (1020+5 wraps modulo 1024).
